// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: load funct3 codes,
// the queued-entry layout and the load alignment/extension function.
package wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // Byte/half is picked by the low address bits; misalignment is not checked.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] rdata);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_res;
    w_byte = rdata[{addr_lo, 3'b000} +: 8];
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      w_res = {{24{w_byte[7]}}, w_byte};
      LH:      w_res = {{16{w_half[15]}}, w_half};
      LBU:     w_res = {24'h0, w_byte};
      LHU:     w_res = {16'h0, w_half};
      default: w_res = rdata;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-return queue. Each slot carries a live bit that can be cleared in place
// by a matching-rd kill, so a younger ALU write suppresses the stale load.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               i_push,
  input  logic               i_push_live,
  input  logic [4:0]         i_push_rd,
  input  logic [31:0]        i_push_data,
  input  logic               i_pop,
  input  logic               i_kill_en,
  input  logic [4:0]         i_kill_rd,
  output logic               o_head_live,
  output logic [4:0]         o_head_rd,
  output logic [31:0]        o_head_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [DEPTH-1:0]   o_live,
  output logic [DEPTH*5-1:0] o_rd_flat
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [DEPTH-1:0] r_live;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];

  logic [AW-1:0]    w_wr_idx, w_rd_idx;
  logic             w_push, w_pop;
  wb_entry_t        w_head;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // A live bit is only ever set on an occupied slot, so it doubles as the valid bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && (r_rd[i] == i_kill_rd)) r_live[i] <= 1'b0;
      end
      if (w_pop)  r_live[w_rd_idx] <= 1'b0;
      if (w_push) r_live[w_wr_idx] <= i_push_live;
    end
  end

  // NOTE: payload storage has no reset; nothing reads it until a live bit, which is reset, marks it valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_rd[w_wr_idx]   <= i_push_rd;
      r_data[w_wr_idx] <= i_push_data;
    end
  end

  assign w_head = '{live: r_live[w_rd_idx], rd: r_rd[w_rd_idx], data: r_data[w_rd_idx]};
  assign o_head_live = w_head.live;
  assign o_head_rd   = w_head.rd;
  assign o_head_data = w_head.data;
  assign o_live      = r_live;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd_flat
    assign o_rd_flat[g*5 +: 5] = r_rd[g];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter: ALU results always win the regfile write port,
// queued load returns drain when the ALU is idle; exports a pending-load busy mask.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [1:0]  lsu_addr_lo_i,
  input  logic [31:0] lsu_rdata_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wren_o,
  output logic [31:0] busy_o
);

  wb_entry_t          w_push_entry;
  logic               w_alu_kill;
  logic               w_push, w_pop;
  logic               w_full, w_empty;
  logic               w_head_live;
  logic [4:0]         w_head_rd;
  logic [31:0]        w_head_data;
  logic [DEPTH-1:0]   w_live;
  logic [DEPTH*5-1:0] w_rd_flat;
  logic               w_wr_en;
  logic [4:0]         w_wr_rd;
  logic [31:0]        w_wr_data;
  logic [31:0]        w_busy;
  logic               r_wren;
  logic [4:0]         r_addr;
  logic [31:0]        r_data;

  // An ALU write is younger than every queued or same-cycle load to the same rd.
  assign w_alu_kill = alu_valid_i && (alu_rd_i != 5'd0);

  assign w_push_entry = '{
    live: (lsu_rd_i != 5'd0) && !(w_alu_kill && (alu_rd_i == lsu_rd_i)),
    rd:   lsu_rd_i,
    data: load_extend(lsu_funct3_i, lsu_addr_lo_i, lsu_rdata_i)
  };

  assign w_push = lsu_valid_i && !w_full;
  assign w_pop  = !alu_valid_i && !w_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_push),
    .i_push_live (w_push_entry.live),
    .i_push_rd   (w_push_entry.rd),
    .i_push_data (w_push_entry.data),
    .i_pop       (w_pop),
    .i_kill_en   (w_alu_kill),
    .i_kill_rd   (alu_rd_i),
    .o_head_live (w_head_live),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_live      (w_live),
    .o_rd_flat   (w_rd_flat)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_rd   = alu_rd_i;
    w_wr_data = alu_data_i;
    if (alu_valid_i) begin
      w_wr_en = (alu_rd_i != 5'd0);
    end else if (w_pop) begin
      w_wr_en   = w_head_live && (w_head_rd != 5'd0);
      w_wr_rd   = w_head_rd;
      w_wr_data = w_head_data;
    end
  end

  // Address/data hold their last written value whenever the enable is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wren <= w_wr_en;
      if (w_wr_en) begin
        r_addr <= w_wr_rd;
        r_data <= w_wr_data;
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i]) w_busy[w_rd_flat[i*5 +: 5]] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end

  assign rd_wren_o   = r_wren;
  assign rd_addr_o   = r_addr;
  assign rd_data_o   = r_data;
  assign busy_o      = w_busy;
  assign lsu_ready_o = !w_full;

endmodule
